flag_pipe_unit: RTL and testbench
=================================

// Module: flag_pipe_unit
// PURPOSE
//  Parametrised, pipelined flag generator for the ALU result/compare path.
//  Per operand pair (a,b) produces zero(a), equal(a,b), unsigned a<b, signed a<b.
//  Reduction trees are split across PIPE_STAGES register stages with valid/ready flow control.
//  Sticky summary flags accumulate across transactions until cleared.
// PARAMETERS
//  WIDTH        32  operand width in bits; any value >= 2 (need not be a power of 2)
//  PIPE_STAGES  2   register stages between accept and output; 1..4
//  STICKY_EN    1   1: sticky flags implemented; 0: sticky outputs tied 0
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      operand pair valid
//  in_ready     out  1      unit can accept this cycle
//  in_a         in   WIDTH  operand a
//  in_b         in   WIDTH  operand b
//  out_valid    out  1      flag result valid
//  out_ready    in   1      consumer accepts result
//  out_zero     out  1      a == 0
//  out_equal    out  1      a == b
//  out_ult      out  1      a <  b unsigned
//  out_slt      out  1      a <  b two's-complement signed
//  flush        in   1      synchronous: drop all in-flight transactions
//  sticky_clr   in   1      synchronous clear of sticky flags
//  sticky_zero  out  1      set if any delivered result had out_zero=1
//  sticky_neq   out  1      set if any delivered result had out_equal=0
// BEHAVIOUR
//  Reset (async on rst rise): all stage valids=0, out_valid=0, all out_* flags=0,
//    sticky_*=0, in_ready=1 once rst deasserts.
//  Accept: in_valid & in_ready at posedge. Delivery: out_valid & out_ready at posedge.
//  Latency: exactly PIPE_STAGES cycles accept->out_valid when not stalled. Throughput 1/cycle.
//  Stall: stage k advances iff stage k+1 empty or advancing; output stage advances iff
//    !out_valid | out_ready. in_ready = first stage empty or advancing (combinational).
//  out_valid and out_* remain stable while out_valid & !out_ready.
//  Pipelined compute:
//    - bitwise x=a^b and a OR-tree, split into chunks; the split chooses only where the
//      registers sit, not the results.
//    - a zero-extended to the next power of 2 before reduction.
//    - zero = ~|a, equal = ~|(a^b).
//  Compare: ult = borrow of the (WIDTH+1)-bit subtract {0,a}-{0,b};
//    slt = ult ^ a[W-1] ^ b[W-1]. This may be registered alongside the trees.
//  Flags are a pure function of the accepted (a,b); no state leaks between transactions.
//  flush: all stage valids <=0 next cycle, including the output stage. Flags are don't-care
//    while invalid. A same-cycle accept is dropped. Sticky flags are unaffected.
//  Sticky: updated only on delivery cycles.
//    sticky_zero <= sticky_zero | out_zero;  sticky_neq <= sticky_neq | ~out_equal.
//    sticky_clr & delivery in the same cycle: the clear wins, then the delivered value is
//      OR'd in, i.e. sticky <= the new flag only.
//  Reset mid-operation: all in-flight results are lost; no spurious out_valid after release.
//  Boundaries:
//    - a=b=0 -> zero=1, equal=1, ult=0, slt=0.
//    - a = 2^(W-1), b = 0 -> ult=0, slt=1.
//    - Full pipe plus stall: no overwrite; in_ready=0 until the output is taken.
// TESTING
//  1 Reset: assert rst mid-stream with 2 in flight -> out_valid=0, sticky=0, no late outputs.
//  2 Streaming, W=32, S=2: (0,0),(5,5),(3,7),(0x80000000,1) back-to-back
//    -> outputs start cycle 2; flags (zero/eq/ult/slt) are
//    1100, 0100, 0011, 0001.
//  3 Backpressure: out_ready=0 for 5 cycles with in_valid=1
//    -> in_ready drops after the pipe fills; order is preserved; no loss or duplicates.
//  4 Width corner, W=33: a=1<<32, b=1<<32 -> zero=0, equal=1;
//    a=0, b=1<<32 -> slt=0, ult=1.
//  5 Flush with 2 in flight plus a simultaneous accept -> next cycle none emerge; sticky unchanged.
//  6 Sticky: deliver (0,1) then (4,4) -> sticky_zero=1, sticky_neq=1;
//    sticky_clr with (4,4) delivery -> zero=0, neq=0.
//  Random: 10k random (a,b) with random ready stalls checked against a reference
//    model, for S in {1,2,4} and W in {8,32,33}.

Source files
------------

// File: rtl/flag_pipe_unit.sv
// rtl/flag_pipe_unit.sv - pipelined zero/equal/ult/slt flag generator with sticky summary flags
module flag_pipe_unit #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int STICKY_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_zero,
    output logic             out_equal,
    output logic             out_ult,
    output logic             out_slt,
    input  logic             flush,
    input  logic             sticky_clr,
    output logic             sticky_zero,
    output logic             sticky_neq
);
    localparam int LP = $clog2(WIDTH);
    localparam int P  = 1 << LP;
    localparam int S  = PIPE_STAGES;

    // OR-tree levels already folded into the vectors held by stage k
    function automatic int lvl(input int k);
        return (LP * k) / S;
    endfunction

    // Apply n pairwise-OR levels; the OR of the whole vector is preserved
    function automatic logic [P-1:0] or_fold(input logic [P-1:0] v, input int n);
        logic [P-1:0] r;
        logic [P-1:0] t;
        r = v;
        for (int l = 0; l < LP; l++) begin
            if (l < n) begin
                t = '0;
                for (int i = 0; i < P / 2; i++) begin
                    t[i] = r[2*i] | r[2*i+1];
                end
                r = t;
            end
        end
        return r;
    endfunction

    logic [S-1:0]   vld_q;
    logic [S-1:0]   ult_q;
    logic [S-1:0]   slt_q;
    logic [P-1:0]   a_q [S];
    logic [P-1:0]   x_q [S];
    logic [S-1:0]   mv;
    logic [P-1:0]   pad_a;
    logic [P-1:0]   pad_x;
    logic [WIDTH:0] diff;
    logic           cmp_ult;
    logic           cmp_slt;
    logic           deliver;

    always_comb begin
        pad_a = '0;
        pad_x = '0;
        pad_a[WIDTH-1:0] = in_a;
        pad_x[WIDTH-1:0] = in_a ^ in_b;
        diff    = {1'b0, in_a} - {1'b0, in_b};
        cmp_ult = diff[WIDTH];
        cmp_slt = diff[WIDTH] ^ in_a[WIDTH-1] ^ in_b[WIDTH-1];
    end

    // mv[k]: stage k loads this cycle (it is empty or its contents move on)
    always_comb begin
        mv = '0;
        mv[S-1] = !vld_q[S-1] | out_ready;
        for (int k = S - 2; k >= 0; k--) begin
            mv[k] = !vld_q[k] | mv[k+1];
        end
    end

    assign in_ready = mv[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            ult_q <= '0;
            slt_q <= '0;
            for (int k = 0; k < S; k++) begin
                a_q[k] <= '0;
                x_q[k] <= '0;
            end
        end else begin
            if (mv[0]) begin
                vld_q[0] <= in_valid;
                a_q[0]   <= pad_a;
                x_q[0]   <= pad_x;
                ult_q[0] <= cmp_ult;
                slt_q[0] <= cmp_slt;
            end
            for (int k = 1; k < S; k++) begin
                if (mv[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    a_q[k]   <= or_fold(a_q[k-1], lvl(k) - lvl(k-1));
                    x_q[k]   <= or_fold(x_q[k-1], lvl(k) - lvl(k-1));
                    ult_q[k] <= ult_q[k-1];
                    slt_q[k] <= slt_q[k-1];
                end
            end
            if (flush) begin
                vld_q <= '0;
            end
        end
    end

    // Flags are forced low while nothing valid is presented
    assign out_valid = vld_q[S-1];
    assign out_zero  = vld_q[S-1] & ~(|a_q[S-1]);
    assign out_equal = vld_q[S-1] & ~(|x_q[S-1]);
    assign out_ult   = vld_q[S-1] & ult_q[S-1];
    assign out_slt   = vld_q[S-1] & slt_q[S-1];
    assign deliver   = out_valid & out_ready;

    generate
        if (STICKY_EN != 0) begin : g_sticky
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sticky_zero <= 1'b0;
                    sticky_neq  <= 1'b0;
                end else if (deliver || sticky_clr) begin
                    sticky_zero <= (sticky_zero & ~sticky_clr) | (deliver & out_zero);
                    sticky_neq  <= (sticky_neq & ~sticky_clr) | (deliver & ~out_equal);
                end
            end
        end else begin : g_no_sticky
            assign sticky_zero = 1'b0;
            assign sticky_neq  = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_flag_pipe_unit.sv
// tb/tb_flag_pipe_unit.sv - directed and random checks of three flag_pipe_unit configurations
module tb_flag_pipe_unit;
    localparam int WD [3] = '{8, 32, 33};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic        sticky_clr;
    logic [32:0] in_a;
    logic [32:0] in_b;
    logic        ir [3];
    logic        ov [3];
    logic        oz [3];
    logic        oe [3];
    logic        ou [3];
    logic        os [3];
    logic        sz [3];
    logic        sn [3];

    logic [3:0]  q   [3][$];
    logic [3:0]  lg  [3][$];
    logic        msz [3];
    logic        msn [3];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    flag_pipe_unit #(.WIDTH(8), .PIPE_STAGES(1), .STICKY_EN(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_zero(oz[0]), .out_equal(oe[0]), .out_ult(ou[0]), .out_slt(os[0]),
        .flush(flush), .sticky_clr(sticky_clr), .sticky_zero(sz[0]), .sticky_neq(sn[0]));

    flag_pipe_unit #(.WIDTH(32), .PIPE_STAGES(2), .STICKY_EN(1)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_zero(oz[1]), .out_equal(oe[1]), .out_ult(ou[1]), .out_slt(os[1]),
        .flush(flush), .sticky_clr(sticky_clr), .sticky_zero(sz[1]), .sticky_neq(sn[1]));

    flag_pipe_unit #(.WIDTH(33), .PIPE_STAGES(4), .STICKY_EN(1)) u_w33 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .in_a(in_a), .in_b(in_b), .out_valid(ov[2]), .out_ready(out_ready),
        .out_zero(oz[2]), .out_equal(oe[2]), .out_ult(ou[2]), .out_slt(os[2]),
        .flush(flush), .sticky_clr(sticky_clr), .sticky_zero(sz[2]), .sticky_neq(sn[2]));

    // Reference flags {zero, equal, ult, slt} from plain integer arithmetic
    function automatic logic [3:0] ref_flags(input logic [32:0] a, input logic [32:0] b, input int w);
        longint m, ua, ub, sa, sb, half;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
        return {ua == 0, ua == ub, ua < ub, sa < sb};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [3:0] f;
        logic [3:0] e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            f = {oz[i], oe[i], ou[i], os[i]};
            chk($sformatf("sticky_zero_d%0d", i), sz[i], msz[i]);
            chk($sformatf("sticky_neq_d%0d", i), sn[i], msn[i]);
            if (ov[i] && out_ready) begin
                if (q[i].size() == 0) begin
                    chk($sformatf("unexpected_out_d%0d", i), ov[i], 1'b0);
                    e = f;
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("flags_d%0d", i), f, e);
                end
                lg[i].push_back(f);
                msz[i] = (msz[i] & ~sticky_clr) | e[3];
                msn[i] = (msn[i] & ~sticky_clr) | ~e[2];
            end else if (sticky_clr) begin
                msz[i] = 1'b0;
                msn[i] = 1'b0;
            end
            if (in_valid && ir[i] && !flush) q[i].push_back(ref_flags(in_a, in_b, WD[i]));
            if (flush) q[i].delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [32:0] a, input logic [32:0] b);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        cycle();
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) cycle();
    endtask

    int          acc;
    int          n;
    int          r;
    logic [3:0]  want2 [4];
    logic [3:0]  want4 [2];

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; sticky_clr = 1'b0;
        in_a = '0; in_b = '0;
        for (int i = 0; i < 3; i++) begin msz[i] = 1'b0; msn[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid_d%0d", i), ov[i], 1'b0);
            chk($sformatf("rst_flags_d%0d", i), {oz[i], oe[i], ou[i], os[i]}, 4'b0000);
            chk($sformatf("rst_sticky_d%0d", i), {sz[i], sn[i]}, 2'b00);
        end
        rst = 1'b0;
        #1;
        chk("rst_in_ready", ir[1], 1'b1);

        // streaming: latency 2 on the S=2 unit and the four reference patterns
        for (int i = 0; i < 3; i++) lg[i].delete();
        out_ready = 1'b1;
        want2 = '{4'b1100, 4'b0100, 4'b0011, 4'b0001};
        chk("lat_edge0", ov[1], 1'b0);
        send(33'd0, 33'd0);
        chk("lat_edge1", ov[1], 1'b0);
        send(33'd5, 33'd5);
        chk("lat_edge2", ov[1], 1'b1);
        send(33'd3, 33'd7);
        send(33'h0_8000_0000, 33'd1);
        drain(6);
        chk("stream_count", lg[1].size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("stream_flags%0d", k), lg[1][k], want2[k]);

        // width corner on the 33-bit unit
        for (int i = 0; i < 3; i++) lg[i].delete();
        want4 = '{4'b0100, 4'b1010};
        send(33'h1_0000_0000, 33'h1_0000_0000);
        send(33'd0, 33'h1_0000_0000);
        drain(8);
        chk("w33_count", lg[2].size(), 2);
        for (int k = 0; k < 2; k++) chk($sformatf("w33_flags%0d", k), lg[2][k], want4[k]);

        // backpressure: S=2 unit takes exactly two then deasserts in_ready
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_a = 33'({$urandom(), $urandom()});
            in_b = 33'({$urandom(), $urandom()});
            if (ir[1]) acc++;
            cycle();
        end
        chk("bp_in_ready", ir[1], 1'b0);
        chk("bp_accepts", acc, 2);
        drain(10);
        chk("bp_drained", q[1].size() + q[2].size() + q[0].size(), 0);

        // flush with items in flight and a simultaneous accept
        out_ready = 1'b0;
        send(33'd9, 33'd2);
        send(33'd0, 33'd0);
        flush = 1'b1;
        send(33'd1, 33'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("flush_out_valid_d%0d", i), ov[i], 1'b0);
        drain(8);

        // sticky accumulate, then clear coinciding with a delivery
        sticky_clr = 1'b1; in_valid = 1'b0; cycle(); sticky_clr = 1'b0;
        out_ready = 1'b1;
        send(33'd0, 33'd1);
        send(33'd4, 33'd4);
        drain(8);
        chk("sticky_zero_set", sz[1], 1'b1);
        chk("sticky_neq_set", sn[1], 1'b1);
        out_ready = 1'b0;
        send(33'd4, 33'd4);
        in_valid = 1'b0;
        n = 0;
        while (!(ov[0] && ov[1] && ov[2]) && n < 20) begin cycle(); n++; end
        chk("sticky_hold_wait", ov[0] & ov[1] & ov[2], 1'b1);
        out_ready = 1'b1; sticky_clr = 1'b1;
        cycle();
        sticky_clr = 1'b0;
        chk("sticky_zero_clr", sz[1], 1'b0);
        chk("sticky_neq_clr", sn[1], 1'b0);
        drain(4);

        // reset mid-stream with items in flight
        send(33'd0, 33'd3);
        drain(8);
        out_ready = 1'b0;
        send(33'd1, 33'd2);
        send(33'd2, 33'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_out_valid_d%0d", i), ov[i], 1'b0);
            chk($sformatf("midrst_sticky_d%0d", i), {sz[i], sn[i]}, 2'b00);
            q[i].delete();
            msz[i] = 1'b0;
            msn[i] = 1'b0;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        drain(8);

        // random traffic with random backpressure and occasional sticky clears
        for (int k = 0; k < 10000; k++) begin
            in_valid   = ($urandom() % 4) != 0;
            out_ready  = ($urandom() % 3) != 0;
            sticky_clr = ($urandom() % 50) == 0;
            in_a = 33'({$urandom(), $urandom()});
            in_b = 33'({$urandom(), $urandom()});
            r = $urandom() % 8;
            if (r == 0) in_b = in_a;
            if (r == 1) in_a = '0;
            if (r == 2) begin in_a = '0; in_b = '0; end
            if (r == 3) in_a = 33'(1) << ($urandom() % 33);
            cycle();
        end
        sticky_clr = 1'b0;
        drain(10);
        for (int i = 0; i < 3; i++) chk($sformatf("final_empty_d%0d", i), q[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
